// File: rtl/dense_weight_reader.sv
// Dense-layer weight reader: buffers one activation vector, streams the weight ROM in address
// order and accumulates one signed dot product per output neuron.
module dense_weight_reader #(
    parameter int numInputs         = 169,
    parameter int numOutputs        = 3,
    parameter int addressWidthDense = 10,
    parameter int dataWidthDense    = 8,
    parameter int accWidth          = 24,
    parameter int offset_ent        = 1,
    localparam int OutIdxW          = (numOutputs > 1) ? $clog2(numOutputs) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic                         act_valid,
    output logic                         act_ready,
    input  logic [dataWidthDense-1:0]    act_data,
    output logic                         mem_en,
    output logic [addressWidthDense-1:0] mem_addr,
    input  logic [dataWidthDense-1:0]    mem_rdata,
    output logic                         out_valid,
    output logic [OutIdxW-1:0]           out_index,
    output logic [accWidth-1:0]          out_data
);

    localparam int InIdxW = (numInputs > 1) ? $clog2(numInputs) : 1;
    localparam int TermW  = dataWidthDense + 2;
    localparam int ProdW  = dataWidthDense + TermW;

    localparam logic [InIdxW-1:0]            IN_LAST   = InIdxW'(numInputs - 1);
    localparam logic [addressWidthDense-1:0] ADDR_LAST = addressWidthDense'(numInputs * numOutputs - 1);
    localparam logic signed [TermW-1:0]      OFFSET    = TermW'(offset_ent);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    // Sequencer state
    state_t                       state_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         act_ready_q;
    logic                         mem_en_q;
    logic                         drain_q;
    logic [addressWidthDense-1:0] mem_addr_q;
    logic [InIdxW-1:0]            in_idx_q;
    logic [OutIdxW-1:0]           neuron_q;

    logic                         beat;
    logic [dataWidthDense-1:0]    act_buf_q [numInputs];

    // Read-return pipeline: tags describing the word arriving on mem_rdata this cycle
    logic                         rd_valid_q;
    logic                         rd_first_q;
    logic                         rd_last_q;
    logic [InIdxW-1:0]            rd_idx_q;
    logic [OutIdxW-1:0]           rd_neuron_q;

    logic signed [TermW-1:0]      act_term;
    logic signed [ProdW-1:0]      product;
    logic [accWidth-1:0]          acc_d;
    logic [accWidth-1:0]          acc_q;

    logic                         out_valid_q;
    logic [OutIdxW-1:0]           out_index_q;
    logic [accWidth-1:0]          out_data_q;

    assign beat = act_valid && act_ready_q;

    // NOTE: reset here is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            act_ready_q <= 1'b0;
            mem_en_q    <= 1'b0;
            drain_q     <= 1'b0;
            mem_addr_q  <= '0;
            in_idx_q    <= '0;
            neuron_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_LOAD;
                        busy_q      <= 1'b1;
                        act_ready_q <= 1'b1;
                        in_idx_q    <= '0;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        if (in_idx_q == IN_LAST) begin
                            state_q     <= S_COMPUTE;
                            act_ready_q <= 1'b0;
                            mem_en_q    <= 1'b1;
                            mem_addr_q  <= '0;
                            in_idx_q    <= '0;
                            neuron_q    <= '0;
                        end else begin
                            in_idx_q <= in_idx_q + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (mem_addr_q == ADDR_LAST) begin
                        state_q  <= S_DRAIN;
                        mem_en_q <= 1'b0;
                        drain_q  <= 1'b0;
                    end else begin
                        mem_addr_q <= mem_addr_q + 1'b1;
                        if (in_idx_q == IN_LAST) begin
                            in_idx_q <= '0;
                            neuron_q <= neuron_q + 1'b1;
                        end else begin
                            in_idx_q <= in_idx_q + 1'b1;
                        end
                    end
                end
                // Two cycles: one for the last ROM word to return, one for its sum to be published.
                S_DRAIN: begin
                    if (drain_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the activation buffer is plain storage with no reset; every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && beat) begin
            act_buf_q[in_idx_q] <= act_data;
        end
    end

    always_comb begin
        act_term = $signed({2'b00, act_buf_q[rd_idx_q]}) + OFFSET;
        product  = $signed(mem_rdata) * act_term;
        acc_d    = rd_first_q ? accWidth'(product) : acc_q + accWidth'(product);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q  <= 1'b0;
            rd_first_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_idx_q    <= '0;
            rd_neuron_q <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
        end else begin
            rd_valid_q  <= mem_en_q;
            rd_first_q  <= (in_idx_q == '0);
            rd_last_q   <= (in_idx_q == IN_LAST);
            rd_idx_q    <= in_idx_q;
            rd_neuron_q <= neuron_q;
            out_valid_q <= 1'b0;
            if (rd_valid_q) begin
                acc_q <= acc_d;
                if (rd_last_q) begin
                    out_valid_q <= 1'b1;
                    out_index_q <= rd_neuron_q;
                    out_data_q  <= acc_d;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign act_ready = act_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_dense_weight_reader.sv
// Directed bench: a 4x2 instance for timing, sign, gap and abort cases plus a default 169x3 instance.
`timescale 1ns/1ps
module tb_dense_weight_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Small 4-input, 2-neuron instance
    logic        s_rst, s_start, s_act_valid;
    logic [7:0]  s_act_data;
    logic        s_busy, s_done, s_act_ready, s_mem_en;
    logic [9:0]  s_mem_addr;
    logic [7:0]  s_mem_rdata;
    logic        s_out_valid;
    logic [0:0]  s_out_index;
    logic [23:0] s_out_data;
    logic [7:0]  s_rom  [8];
    logic [7:0]  s_acts [4];

    dense_weight_reader #(.numInputs(4), .numOutputs(2)) u_small (
        .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy), .done(s_done),
        .act_valid(s_act_valid), .act_ready(s_act_ready), .act_data(s_act_data),
        .mem_en(s_mem_en), .mem_addr(s_mem_addr), .mem_rdata(s_mem_rdata),
        .out_valid(s_out_valid), .out_index(s_out_index), .out_data(s_out_data)
    );

    always @(posedge clk) if (s_mem_en) s_mem_rdata <= s_rom[s_mem_addr[2:0]];

    // Default 169-input, 3-neuron instance
    logic        b_rst, b_start, b_act_valid;
    logic [7:0]  b_act_data;
    logic        b_busy, b_done, b_act_ready, b_mem_en;
    logic [9:0]  b_mem_addr;
    logic [7:0]  b_mem_rdata;
    logic        b_out_valid;
    logic [1:0]  b_out_index;
    logic [23:0] b_out_data;

    dense_weight_reader u_big (
        .clk(clk), .rst(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
        .act_valid(b_act_valid), .act_ready(b_act_ready), .act_data(b_act_data),
        .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
        .out_valid(b_out_valid), .out_index(b_out_index), .out_data(b_out_data)
    );

    // Neuron 0 all +1, neuron 1 all -1, neuron 2 +1 on even inputs and 0 on odd ones.
    function automatic logic [7:0] big_weight(input logic [9:0] a);
        int o;
        int i;
        o = int'(a) / 169;
        i = int'(a) % 169;
        if (o == 0) return 8'h01;
        if (o == 1) return 8'hFF;
        return (i % 2 == 0) ? 8'h01 : 8'h00;
    endfunction

    always @(posedge clk) if (b_mem_en) b_mem_rdata <= big_weight(b_mem_addr);

    // Event logs, sampled on the falling edge
    int          s_en_cyc[$];
    int          s_addr[$];
    int          s_ov_cyc[$];
    int          s_ov_idx[$];
    logic [23:0] s_ov_dat[$];
    int          s_done_cyc[$];
    int          s_ready_cnt = 0;

    int          b_en_cnt = 0;
    int          b_en_first = -1;
    int          b_ready_cnt = 0;
    int          b_ov_cyc[$];
    int          b_ov_idx[$];
    logic [23:0] b_ov_dat[$];
    int          b_done_cyc[$];

    always @(negedge clk) begin
        if (s_mem_en) begin
            s_en_cyc.push_back(cyc);
            s_addr.push_back(int'(s_mem_addr));
        end
        if (s_out_valid) begin
            s_ov_cyc.push_back(cyc);
            s_ov_idx.push_back(int'(s_out_index));
            s_ov_dat.push_back(s_out_data);
        end
        if (s_done) s_done_cyc.push_back(cyc);
        if (s_act_ready) s_ready_cnt++;
        if (b_mem_en) begin
            if (b_en_cnt == 0) b_en_first = cyc;
            b_en_cnt++;
        end
        if (b_out_valid) begin
            b_ov_cyc.push_back(cyc);
            b_ov_idx.push_back(int'(b_out_index));
            b_ov_dat.push_back(b_out_data);
        end
        if (b_done) b_done_cyc.push_back(cyc);
        if (b_act_ready) b_ready_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_small();
        s_en_cyc.delete();
        s_addr.delete();
        s_ov_cyc.delete();
        s_ov_idx.delete();
        s_ov_dat.delete();
        s_done_cyc.delete();
        s_ready_cnt = 0;
    endtask

    // Runs one job on the small instance: 'gaps' idle cycles between beats, bounded wait for done.
    task automatic small_job(input int gaps, output int c0, output bit timeout);
        clear_small();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gaps && i > 0; g++) begin
                s_act_valid = 1'b0;
                s_act_data  = 8'hAA;
                tick();
            end
            s_act_valid = 1'b1;
            s_act_data  = s_acts[i];
            c0 = cyc + 1;
            tick();
        end
        s_act_valid = 1'b0;
        timeout = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (s_done_cyc.size() > 0) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        s_rst = 1'b1; s_start = 1'b0; s_act_valid = 1'b0; s_act_data = 8'h00;
        b_rst = 1'b1; b_start = 1'b0; b_act_valid = 1'b0; b_act_data = 8'h00;
        for (int i = 0; i < 8; i++) s_rom[i] = 8'h00;
        repeat (3) tick();
        total++;
        if ({s_busy, s_done, s_act_ready, s_mem_en, s_out_valid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 00000", {s_busy, s_done, s_act_ready, s_mem_en, s_out_valid});
        end
        total++;
        if ({s_mem_addr, s_out_index, s_out_data} !== 35'd0) begin
            bad++;
            $display("FAIL reset_data: addr=%0d idx=%0d data=%0d expected all 0", s_mem_addr, s_out_index, s_out_data);
        end
        total++;
        if ({b_busy, b_act_ready, b_mem_en, b_out_valid} !== 4'b0) begin
            bad++;
            $display("FAIL reset_big: got %b expected 0000", {b_busy, b_act_ready, b_mem_en, b_out_valid});
        end
        s_rst = 1'b0;
        b_rst = 1'b0;
        tick();
        tick();
        total++;
        if ({s_busy, s_act_ready} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset: got %b expected 00", {s_busy, s_act_ready});
        end
    endtask

    task automatic test_basic();
        int c0;
        bit to;
        for (int i = 0; i < 8; i++) s_rom[i] = 8'h01;
        for (int i = 0; i < 4; i++) s_acts[i] = 8'(i);
        small_job(0, c0, to);
        total++;
        if (to) begin bad++; $display("FAIL basic_timeout: no done within bound"); end
        total++;
        if (s_ov_dat.size() !== 2 || s_done_cyc.size() !== 1) begin
            bad++;
            $display("FAIL basic_counts: out_valid=%0d done=%0d expected 2 and 1", s_ov_dat.size(), s_done_cyc.size());
        end
        total++;
        if (s_ov_dat[0] !== 24'd10 || s_ov_idx[0] !== 0) begin
            bad++;
            $display("FAIL basic_n0: data=%0d idx=%0d expected 10 idx 0", s_ov_dat[0], s_ov_idx[0]);
        end
        total++;
        if (s_ov_dat[1] !== 24'd10 || s_ov_idx[1] !== 1) begin
            bad++;
            $display("FAIL basic_n1: data=%0d idx=%0d expected 10 idx 1", s_ov_dat[1], s_ov_idx[1]);
        end
        total++;
        if (s_ready_cnt !== 4 || s_busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_ready_busy: ready cycles=%0d busy=%b expected 4 and 0", s_ready_cnt, s_busy);
        end
    endtask

    task automatic test_sign();
        int c0;
        bit to;
        for (int i = 0; i < 4; i++) begin
            s_rom[i]     = 8'hFF;
            s_rom[4 + i] = 8'(i + 1);
            s_acts[i]    = 8'hFF;
        end
        small_job(0, c0, to);
        total++;
        if (to || s_ov_dat.size() !== 2) begin
            bad++;
            $display("FAIL sign_counts: timeout=%0d out_valid=%0d expected 0 and 2", to, s_ov_dat.size());
        end
        total++;
        if (s_ov_dat[0] !== 24'hFFFC00) begin
            bad++;
            $display("FAIL sign_n0: got %h expected fffc00", s_ov_dat[0]);
        end
        total++;
        if (s_ov_dat[1] !== 24'd2560) begin
            bad++;
            $display("FAIL sign_n1: got %0d expected 2560", s_ov_dat[1]);
        end
    endtask

    task automatic test_gaps();
        int c0;
        bit to;
        s_rom[0] = 8'h01; s_rom[1] = 8'h02; s_rom[2] = 8'h03; s_rom[3] = 8'h04;
        s_rom[4] = 8'hFE; s_rom[5] = 8'h00; s_rom[6] = 8'h01; s_rom[7] = 8'h7F;
        s_acts[0] = 8'd5; s_acts[1] = 8'd7; s_acts[2] = 8'd9; s_acts[3] = 8'd11;
        s_act_valid = 1'b1;
        s_act_data  = 8'hEE;
        tick();
        tick();
        small_job(2, c0, to);
        total++;
        if (to || s_ov_dat.size() !== 2) begin
            bad++;
            $display("FAIL gaps_counts: timeout=%0d out_valid=%0d expected 0 and 2", to, s_ov_dat.size());
        end
        total++;
        if (s_ov_dat[0] !== 24'd100 || s_ov_dat[1] !== 24'd1522) begin
            bad++;
            $display("FAIL gaps_sums: got %0d,%0d expected 100,1522", s_ov_dat[0], s_ov_dat[1]);
        end
        total++;
        if (s_en_cyc[0] !== c0 || s_en_cyc.size() !== 8) begin
            bad++;
            $display("FAIL gaps_mem_en: first=%0d count=%0d expected %0d and 8", s_en_cyc[0], s_en_cyc.size(), c0);
        end
        total++;
        if (s_ready_cnt !== 10) begin
            bad++;
            $display("FAIL gaps_ready: got %0d cycles expected 10", s_ready_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        bit to;
        small_job(0, c0, to);
        total++;
        if (to || s_addr.size() !== 8) begin
            bad++;
            $display("FAIL b2b_counts: timeout=%0d addrs=%0d expected 0 and 8", to, s_addr.size());
        end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (s_addr[j] !== j || s_en_cyc[j] !== c0 + j) begin
                bad++;
                $display("FAIL b2b_addr%0d: addr=%0d cycle=%0d expected %0d at %0d", j, s_addr[j], s_en_cyc[j], j, c0 + j);
            end
        end
        total++;
        if (s_ov_cyc[0] !== c0 + 5 || s_ov_cyc[1] !== c0 + 9) begin
            bad++;
            $display("FAIL b2b_out_cycles: got %0d,%0d expected %0d,%0d", s_ov_cyc[0], s_ov_cyc[1], c0 + 5, c0 + 9);
        end
        total++;
        if (s_done_cyc[0] !== c0 + 10 || s_done_cyc.size() !== 1) begin
            bad++;
            $display("FAIL b2b_done: cycle=%0d count=%0d expected %0d and 1", s_done_cyc[0], s_done_cyc.size(), c0 + 10);
        end
        total++;
        if (s_out_data !== 24'd1522 || s_out_index !== 1'b1) begin
            bad++;
            $display("FAIL b2b_hold: data=%0d idx=%0d expected 1522 idx 1", s_out_data, s_out_index);
        end
    endtask

    task automatic test_abort();
        int c0;
        bit to;
        for (int i = 0; i < 8; i++) s_rom[i] = 8'h01;
        for (int i = 0; i < 4; i++) s_acts[i] = 8'(i);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_act_valid = 1'b1;
            s_act_data  = s_acts[i];
            tick();
        end
        s_act_valid = 1'b0;
        repeat (3) tick();
        s_rst = 1'b1;
        tick();
        total++;
        if ({s_busy, s_mem_en, s_out_valid, s_done, s_act_ready} !== 5'b0) begin
            bad++;
            $display("FAIL abort_ctrl: got %b expected 00000", {s_busy, s_mem_en, s_out_valid, s_done, s_act_ready});
        end
        total++;
        if (s_out_data !== 24'd0 || s_mem_addr !== 10'd0) begin
            bad++;
            $display("FAIL abort_data: data=%0d addr=%0d expected 0 and 0", s_out_data, s_mem_addr);
        end
        s_rst = 1'b0;
        clear_small();
        repeat (12) tick();
        total++;
        if (s_ov_cyc.size() !== 0 || s_done_cyc.size() !== 0) begin
            bad++;
            $display("FAIL abort_stray: out_valid=%0d done=%0d expected 0 and 0", s_ov_cyc.size(), s_done_cyc.size());
        end
        small_job(0, c0, to);
        total++;
        if (to || s_ov_dat.size() !== 2 || s_ov_dat[0] !== 24'd10 || s_ov_dat[1] !== 24'd10) begin
            bad++;
            $display("FAIL abort_rerun: timeout=%0d n=%0d data=%0d,%0d expected 10,10", to, s_ov_dat.size(), s_ov_dat[0], s_ov_dat[1]);
        end
    endtask

    task automatic test_full();
        int c0;
        bit to;
        logic [23:0] exp_n1;
        exp_n1 = 24'(-14365);
        c0 = 0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 169; i++) begin
            b_act_valid = 1'b1;
            b_act_data  = 8'(i);
            c0 = cyc + 1;
            tick();
        end
        b_act_valid = 1'b0;
        b_start = 1'b1;
        repeat (300) tick();
        b_start = 1'b0;
        to = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if (b_done_cyc.size() > 0) begin
                to = 1'b0;
                break;
            end
            tick();
        end
        repeat (3) tick();
        total++;
        if (to || b_ov_dat.size() !== 3) begin
            bad++;
            $display("FAIL full_counts: timeout=%0d out_valid=%0d expected 0 and 3", to, b_ov_dat.size());
        end
        total++;
        if (b_ov_dat[0] !== 24'd14365 || b_ov_dat[1] !== exp_n1 || b_ov_dat[2] !== 24'd7225) begin
            bad++;
            $display("FAIL full_sums: got %0d,%0d,%0d expected 14365,-14365,7225",
                     $signed(b_ov_dat[0]), $signed(b_ov_dat[1]), $signed(b_ov_dat[2]));
        end
        total++;
        if (b_ov_idx[0] !== 0 || b_ov_idx[1] !== 1 || b_ov_idx[2] !== 2) begin
            bad++;
            $display("FAIL full_index: got %0d,%0d,%0d expected 0,1,2", b_ov_idx[0], b_ov_idx[1], b_ov_idx[2]);
        end
        total++;
        if (b_ov_cyc[0] !== c0 + 170 || b_ov_cyc[1] !== c0 + 339 || b_ov_cyc[2] !== c0 + 508) begin
            bad++;
            $display("FAIL full_out_cycles: got %0d,%0d,%0d expected %0d,%0d,%0d",
                     b_ov_cyc[0], b_ov_cyc[1], b_ov_cyc[2], c0 + 170, c0 + 339, c0 + 508);
        end
        total++;
        if (b_done_cyc[0] !== c0 + 509 || b_done_cyc.size() !== 1) begin
            bad++;
            $display("FAIL full_done: cycle=%0d count=%0d expected %0d and 1", b_done_cyc[0], b_done_cyc.size(), c0 + 509);
        end
        total++;
        if (b_en_first !== c0 || b_en_cnt !== 507) begin
            bad++;
            $display("FAIL full_mem_en: first=%0d count=%0d expected %0d and 507", b_en_first, b_en_cnt, c0);
        end
        total++;
        if (b_ready_cnt !== 169 || b_busy !== 1'b0) begin
            bad++;
            $display("FAIL full_start_ignored: ready cycles=%0d busy=%b expected 169 and 0", b_ready_cnt, b_busy);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_gaps();
        test_back_to_back();
        test_abort();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
